pwm_sched_ctrl: RTL and testbench
=================================

Name: pwm_sched_ctrl

Overview:
- Multi-channel PWM controller: one shared period counter drives NUM_CH duty comparators.
- Configured through a simple register-write port from the top-level pin mapping (ui_in/uio_in).
- Double-buffered: writes land in staging registers; active registers reload only at the period boundary, so every output period is glitch-free.

Parameters:
- NUM_CH, 4, number of PWM channels
- CNT_W, 8, counter/duty/period width in bits
- ADDR_W, 3, register address width

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- wr_en  input  1  register write strobe, one write per cycle
- wr_addr  input  ADDR_W  register address
- wr_data  input  CNT_W  write data
- pwm_out  output  NUM_CH  PWM outputs, registered
- cnt_o  output  CNT_W  current counter value
- period_sync  output  1  one-cycle pulse on counter wrap
- running  output  1  run bit of the CTRL register, as currently held

Behaviour:
- Register map (staging):
  - 0..NUM_CH-1: DUTY[i]
  - 4: TOP (period = TOP+1 cycles)
  - 5: EN mask, bits [NUM_CH-1:0]
  - 6: CTRL, bit0 = run
  - 7: ignored
- Write semantics: wr_data is truncated/zero-extended per register. Writes to unused bits or addr 7 have no effect.
- Reset (async, rst_n=0):
  - DUTY = 0, TOP = 8'hFF, EN = 0, run = 0.
  - Active copies equal the staging values.
  - cnt_o = 0, pwm_out = 0, period_sync = 0, running = 0.
- Stopped (run=0):
  - cnt_o held at 0; pwm_out = 0; period_sync = 0.
  - Active registers copy staging every cycle.
- Run start: on the edge where run goes 0→1 (CTRL write), the counter starts. The first running cycle has cnt_o = 0.
- Running:
  - cnt_o increments each cycle.
  - When cnt_o == TOP_active: the next value is 0, period_sync = 1 that cycle, and the active DUTY/TOP/EN load from staging on the same edge.
- Simultaneous write and wrap:
  - The reload captures staging as it was before the edge.
  - The simultaneous write takes effect at the following wrap.
- Run stop:
  - A CTRL write with run=0 clears cnt_o to 0 on the next edge.
  - pwm_out goes 0 one cycle later.
  - No partial-period completion.
- Output compare:
  - Each edge: pwm_out[i] <= running_q & EN_active[i] & (cnt_o < DUTY_active[i]).
  - pwm_out therefore lags cnt_o by exactly one cycle.
- Duty boundaries:
  - DUTY = 0 → constant low.
  - DUTY > TOP → constant high for the whole period.
  - DUTY = TOP+1 → high for the whole period.
- TOP = 0:
  - Counter stays 0 and every cycle is a wrap; period_sync is held high.
  - Output is high iff DUTY ≥ 1.
- Counter never exceeds TOP_active. If TOP staging is lowered, it takes effect only at the wrap.
- Reset mid-period: immediate return to the reset values above, with no wait for a clock edge.

Decomposition:
- Package pwm_pkg:
  - Address constants ADDR_DUTY0, ADDR_TOP, ADDR_EN, ADDR_CTRL.
  - Reset constant TOP_RST = 8'hFF.
  - CNT_W default.
- Sub-module pwm_channel:
  - Holds the staging and active duty registers, the comparator and the output flop.
  - Has a load input.
  - Instantiated NUM_CH times by generate.
- Counter, TOP/EN/CTRL registers and write decode stay in pwm_sched_ctrl.

Test Plan:
1. Reset only, run=0 for 20 cycles → pwm_out = 0, cnt_o = 0, period_sync = 0, running = 0.
2. TOP=9, DUTY0=3, EN=4'b0001, run=1 → cnt_o cycles 0..9; pwm_out[0] high 3 of every 10 cycles, one cycle after cnt_o = 0; period_sync pulses every 10 cycles at cnt_o = 9.
3. Mid-period with TOP=9, DUTY0=3: write DUTY0=7 at cnt_o=4 → current period keeps 3 high cycles; next period has 7. Write DUTY0=5 exactly at cnt_o=9 → the next period still uses 7 and the 5 applies one period later.
4. DUTY=0 on ch1, DUTY=200 on ch2, TOP=9, EN=4'b0110 → pwm_out[1] constant 0, pwm_out[2] constant 1, pwm_out[3] 0 (disabled).
5. TOP=0, DUTY0=1, EN=1, run=1 → period_sync constant 1, pwm_out[0] constant 1 after one cycle latency; then DUTY0=0 → low from the next wrap plus one cycle.
6. Running, assert rst_n=0 asynchronously at cnt_o=5 → all outputs 0 with no clock edge; after release, TOP reads 8'hFF behaviour and run=0.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants, register-select type and address decode for the
// double-buffered multi-channel PWM controller.
package pwm_pkg;

  localparam int CNT_W_DEF  = 8;
  localparam int ADDR_W_DEF = 3;

  localparam int unsigned ADDR_DUTY0 = 0;
  localparam int unsigned ADDR_TOP   = 4;
  localparam int unsigned ADDR_EN    = 5;
  localparam int unsigned ADDR_CTRL  = 6;

  localparam logic [CNT_W_DEF-1:0] TOP_RST = 8'hFF;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_DUTY,
    SEL_TOP,
    SEL_EN,
    SEL_CTRL
  } reg_sel_e;

  // Unsigned subtraction wraps for addresses below the duty base, so one compare covers the range.
  function automatic reg_sel_e decode_addr(input int unsigned addr, input int unsigned num_ch);
    reg_sel_e sel;
    sel = SEL_NONE;
    if ((addr - ADDR_DUTY0) < num_ch) sel = SEL_DUTY;
    else if (addr == ADDR_TOP)        sel = SEL_TOP;
    else if (addr == ADDR_EN)         sel = SEL_EN;
    else if (addr == ADDR_CTRL)       sel = SEL_CTRL;
    return sel;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: staging and active duty registers, the comparator
// against the shared counter, and the registered output.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_duty,
  input  logic [CNT_W-1:0] wr_data,
  input  logic             load,
  input  logic             run,
  input  logic             en,
  input  logic [CNT_W-1:0] cnt,
  output logic             pwm_out
);

  logic [CNT_W-1:0] duty_stage_q, duty_stage_d;
  logic [CNT_W-1:0] duty_act_q, duty_act_d;
  logic             pwm_q, pwm_d;

  always_comb begin
    duty_stage_d = wr_duty ? wr_data : duty_stage_q;
    duty_act_d   = load ? duty_stage_q : duty_act_q;
    pwm_d        = run & en & (cnt < duty_act_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_stage_q <= '0;
      duty_act_q   <= '0;
      pwm_q        <= 1'b0;
    end else begin
      duty_stage_q <= duty_stage_d;
      duty_act_q   <= duty_act_d;
      pwm_q        <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/pwm_sched_ctrl.sv
// Multi-channel PWM controller: shared period counter, register write decode
// and double-buffered TOP/EN registers; per-channel duty lives in pwm_channel.
module pwm_sched_ctrl
  import pwm_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CNT_W-1:0]  wr_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              period_sync,
  output logic              running
);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  top_stage_q, top_stage_d;
  logic [CNT_W-1:0]  top_act_q, top_act_d;
  logic [NUM_CH-1:0] en_stage_q, en_stage_d;
  logic [NUM_CH-1:0] en_act_q, en_act_d;
  logic              run_q, run_d;
  logic [NUM_CH-1:0] duty_wr;
  reg_sel_e          sel;
  logic              wrap;
  logic              load;

  always_comb begin
    sel         = wr_en ? decode_addr(32'(wr_addr), NUM_CH) : SEL_NONE;
    top_stage_d = top_stage_q;
    en_stage_d  = en_stage_q;
    run_d       = run_q;
    duty_wr     = '0;
    case (sel)
      SEL_TOP:  top_stage_d = wr_data;
      SEL_EN:   en_stage_d  = wr_data[NUM_CH-1:0];
      SEL_CTRL: run_d       = wr_data[0];
      default:  ;
    endcase
    for (int i = 0; i < NUM_CH; i++) begin
      duty_wr[i] = (sel == SEL_DUTY) && ((32'(wr_addr) - ADDR_DUTY0) == 32'(i));
    end

    // While stopped the active copies track staging every cycle; while running only at the wrap.
    wrap      = run_q && (cnt_q == top_act_q);
    load      = !run_q || wrap;
    top_act_d = load ? top_stage_q : top_act_q;
    en_act_d  = load ? en_stage_q : en_act_q;

    cnt_d = '0;
    if (run_q && run_d && !wrap) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      top_stage_q <= CNT_W'(TOP_RST);
      top_act_q   <= CNT_W'(TOP_RST);
      en_stage_q  <= '0;
      en_act_q    <= '0;
      run_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      top_stage_q <= top_stage_d;
      top_act_q   <= top_act_d;
      en_stage_q  <= en_stage_d;
      en_act_q    <= en_act_d;
      run_q       <= run_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_duty(duty_wr[i]),
      .wr_data(wr_data),
      .load   (load),
      .run    (run_q),
      .en     (en_act_q[i]),
      .cnt    (cnt_q),
      .pwm_out(pwm_out[i])
    );
  end

  assign cnt_o       = cnt_q;
  assign period_sync = wrap;
  assign running     = run_q;

endmodule

// File: tb/tb_pwm_sched_ctrl.sv
// Directed, table-driven bench for pwm_sched_ctrl: configuration, reload
// timing, duty boundaries, TOP=0, stop behaviour and asynchronous reset.
module tb_pwm_sched_ctrl;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] pwm_out;
  logic [7:0] cnt_o;
  logic       period_sync;
  logic       running;

  int checks;
  int failures;

  typedef struct {
    logic       we;
    logic [2:0] addr;
    logic [7:0] data;
    logic [3:0] pwm;
    logic [7:0] cnt;
    logic       sync;
    logic       run;
  } vec_t;

  vec_t vecs[15];

  pwm_sched_ctrl #(
    .NUM_CH(4),
    .CNT_W (8),
    .ADDR_W(3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .pwm_out    (pwm_out),
    .cnt_o      (cnt_o),
    .period_sync(period_sync),
    .running    (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the active edge, so outputs sampled here reflect that edge.
  task automatic applyStimulus(input logic we, input logic [2:0] addr, input logic [7:0] data);
    wr_en   = we;
    wr_addr = addr;
    wr_data = data;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    wr_addr = 3'd0;
    wr_data = 8'd0;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] ep, input logic [7:0] ec,
                             input logic es, input logic er);
    checks++;
    if ({pwm_out, cnt_o, period_sync, running} !== {ep, ec, es, er}) begin
      failures++;
      $display("[TB] FAIL %s: got pwm=%b cnt=%0d sync=%b run=%b, expected pwm=%b cnt=%0d sync=%b run=%b",
               name, pwm_out, cnt_o, period_sync, running, ep, ec, es, er);
    end
  endtask

  function automatic int dutyFor(input int p);
    if (p < 4) return 3;
    if (p < 6) return 7;
    return 5;
  endfunction

  initial begin
    logic [3:0] ep;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = 3'd0;
    wr_data  = 8'd0;

    // Configure TOP=9, DUTY0=3, EN=1, start, then the first 11 running cycles.
    vecs[0]  = '{1'b1, 3'd4, 8'd9, 4'b0000, 8'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 3'd0, 8'd3, 4'b0000, 8'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 3'd5, 8'd1, 4'b0000, 8'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 3'd6, 8'd1, 4'b0000, 8'd0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 3'd0, 8'd0, 4'b0001, 8'd1, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 3'd0, 8'd0, 4'b0001, 8'd2, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 3'd0, 8'd0, 4'b0001, 8'd3, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 3'd0, 8'd0, 4'b0000, 8'd4, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 3'd0, 8'd0, 4'b0000, 8'd5, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 3'd0, 8'd0, 4'b0000, 8'd6, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 3'd0, 8'd0, 4'b0000, 8'd7, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 3'd0, 8'd0, 4'b0000, 8'd8, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 3'd0, 8'd0, 4'b0000, 8'd9, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 3'd0, 8'd0, 4'b0000, 8'd0, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 3'd0, 8'd0, 4'b0001, 8'd1, 1'b0, 1'b1};

    #23;
    rst_n = 1'b1;

    checkOutput("reset", 4'b0000, 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 3'd0, 8'd0);
      checkOutput($sformatf("idle%0d", i), 4'b0000, 8'd0, 1'b0, 1'b0);
    end

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].data);
      checkOutput($sformatf("vec%0d", i), vecs[i].pwm, vecs[i].cnt, vecs[i].sync, vecs[i].run);
    end

    // DUTY0=7 written mid-period (cnt 4), DUTY0=5 written on the wrap cycle itself.
    for (int n = 12; n <= 71; n++) begin
      if (n == 35)      applyStimulus(1'b1, 3'd0, 8'd7);
      else if (n == 50) applyStimulus(1'b1, 3'd0, 8'd5);
      else              applyStimulus(1'b0, 3'd0, 8'd0);
      ep    = 4'b0000;
      ep[0] = ((n - 1) % 10) < dutyFor((n - 1) / 10);
      checkOutput($sformatf("reload n=%0d", n), ep, 8'(n % 10), (n % 10) == 9, 1'b1);
    end

    applyStimulus(1'b1, 3'd6, 8'd0);
    checkOutput("stop edge", 4'b0001, 8'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'd0, 8'd0);
    checkOutput("stop +1", 4'b0000, 8'd0, 1'b0, 1'b0);

    // Boundaries: ch0 DUTY=TOP+1, ch1 DUTY=0, ch2 DUTY>TOP, ch3 disabled.
    applyStimulus(1'b1, 3'd1, 8'd0);
    applyStimulus(1'b1, 3'd2, 8'd200);
    applyStimulus(1'b1, 3'd3, 8'd50);
    applyStimulus(1'b1, 3'd0, 8'd10);
    applyStimulus(1'b1, 3'd5, 8'd7);
    checkOutput("bnd cfg", 4'b0000, 8'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd6, 8'd1);
    checkOutput("bnd start", 4'b0000, 8'd0, 1'b0, 1'b1);
    for (int n = 1; n <= 25; n++) begin
      applyStimulus(1'b0, 3'd0, 8'd0);
      checkOutput($sformatf("bnd n=%0d", n), 4'b0101, 8'(n % 10), (n % 10) == 9, 1'b1);
    end
    applyStimulus(1'b1, 3'd6, 8'd0);
    checkOutput("bnd stop", 4'b0101, 8'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'd0, 8'd0);
    checkOutput("bnd stop +1", 4'b0000, 8'd0, 1'b0, 1'b0);

    // TOP=0; EN written with junk upper bits, addr 7 written with junk.
    applyStimulus(1'b1, 3'd4, 8'd0);
    applyStimulus(1'b1, 3'd0, 8'd1);
    applyStimulus(1'b1, 3'd5, 8'hF1);
    applyStimulus(1'b1, 3'd7, 8'hFF);
    checkOutput("top0 cfg", 4'b0000, 8'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd6, 8'h01);
    checkOutput("top0 start", 4'b0000, 8'd0, 1'b1, 1'b1);
    for (int n = 1; n <= 10; n++) begin
      if (n == 6) applyStimulus(1'b1, 3'd0, 8'd0);
      else        applyStimulus(1'b0, 3'd0, 8'd0);
      ep = (n <= 7) ? 4'b0001 : 4'b0000;
      checkOutput($sformatf("top0 n=%0d", n), ep, 8'd0, 1'b1, 1'b1);
    end
    applyStimulus(1'b1, 3'd6, 8'hFE);
    checkOutput("top0 stop", 4'b0000, 8'd0, 1'b0, 1'b0);

    // Asynchronous reset while running at cnt 5.
    applyStimulus(1'b1, 3'd4, 8'd9);
    applyStimulus(1'b1, 3'd0, 8'd8);
    applyStimulus(1'b1, 3'd6, 8'h01);
    checkOutput("rst start", 4'b0000, 8'd0, 1'b0, 1'b1);
    for (int n = 1; n <= 5; n++) begin
      applyStimulus(1'b0, 3'd0, 8'd0);
      checkOutput($sformatf("rst n=%0d", n), 4'b0001, 8'(n), 1'b0, 1'b1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset", 4'b0000, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 3'd0, 8'd0);
      checkOutput($sformatf("post rst%0d", i), 4'b0000, 8'd0, 1'b0, 1'b0);
    end

    // After reset TOP must be 255 again: a full 256-cycle period.
    applyStimulus(1'b1, 3'd5, 8'd1);
    applyStimulus(1'b1, 3'd0, 8'h80);
    applyStimulus(1'b1, 3'd6, 8'h01);
    checkOutput("ff start", 4'b0000, 8'd0, 1'b0, 1'b1);
    for (int n = 1; n <= 260; n++) begin
      applyStimulus(1'b0, 3'd0, 8'd0);
      ep    = 4'b0000;
      ep[0] = ((n - 1) % 256) < 128;
      if ((n % 32) == 0 || n >= 254)
        checkOutput($sformatf("ff n=%0d", n), ep, 8'(n % 256), (n % 256) == 255, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
